zombie_spawner: RTL and testbench

//  Per-level enemy scheduler sitting directly downstream of the game-state FSM.

---
 rtl/zombie_spawner.sv | 141 ++++++++++++++
 tb/tb_zombie_spawner.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/zombie_spawner.sv
// Three-slot zombie scheduler: spawn delay, approach, reach or kill.
// Drives the level-end 'enemies' flag and per-cycle damage counts.
module zombie_spawner #(
    parameter int                DIST_W     = 10,
    parameter logic [DIST_W-1:0] SPAWN_DIST = 10'd600
) (
    input  logic              Clk,
    input  logic              Reset_h,
    input  logic              frame_tick,
    input  logic              new_level,
    input  logic              play_active,
    input  logic [DIST_W-1:0] z0_speed,
    input  logic [DIST_W-1:0] z1_speed,
    input  logic [DIST_W-1:0] z2_speed,
    input  logic [DIST_W-1:0] z0_delay,
    input  logic [DIST_W-1:0] z1_delay,
    input  logic [DIST_W-1:0] z2_delay,
    input  logic [2:0]        kill,
    output logic [2:0]        zombie_alive,
    output logic [DIST_W-1:0] z0_dist,
    output logic [DIST_W-1:0] z1_dist,
    output logic [DIST_W-1:0] z2_dist,
    output logic              enemies,
    output logic [1:0]        damage_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ALIVE,
        S_DONE
    } state_t;

    state_t            r_state    [3];
    logic [DIST_W-1:0] r_cnt      [3];
    logic [DIST_W-1:0] r_dist     [3];
    logic [2:0]        r_alive;
    logic              r_enemies;
    logic [1:0]        r_dmg;

    state_t            w_state_nx [3];
    logic [DIST_W-1:0] w_cnt_nx   [3];
    logic [DIST_W-1:0] w_dist_nx  [3];
    logic [DIST_W-1:0] w_speed    [3];
    logic [DIST_W-1:0] w_delay    [3];
    logic [2:0]        w_reach;
    logic [2:0]        w_alive_nx;
    logic              w_enemies_nx;
    logic [1:0]        w_dmg_nx;

    assign w_speed[0] = z0_speed;
    assign w_speed[1] = z1_speed;
    assign w_speed[2] = z2_speed;
    assign w_delay[0] = z0_delay;
    assign w_delay[1] = z1_delay;
    assign w_delay[2] = z2_delay;

    always_comb begin
        w_enemies_nx = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w_state_nx[i] = r_state[i];
            w_cnt_nx[i]   = r_cnt[i];
            w_dist_nx[i]  = r_dist[i];
            w_reach[i]    = 1'b0;
            if (new_level) begin
                w_state_nx[i] = S_WAIT;
                w_cnt_nx[i]   = '0;
                w_dist_nx[i]  = '0;
            end else if (!play_active) begin
                w_state_nx[i] = S_IDLE;
                w_cnt_nx[i]   = '0;
                w_dist_nx[i]  = '0;
            end else begin
                unique case (r_state[i])
                    S_WAIT: begin
                        if (frame_tick) begin
                            if (r_cnt[i] == w_delay[i]) begin
                                w_state_nx[i] = S_ALIVE;
                                w_dist_nx[i]  = SPAWN_DIST;
                            end else if (r_cnt[i] != '1) begin
                                w_cnt_nx[i] = r_cnt[i] + 1'b1;
                            end
                        end
                    end
                    S_ALIVE: begin
                        // a kill on the reaching tick denies the damage
                        if (kill[i]) begin
                            w_state_nx[i] = S_DONE;
                            w_dist_nx[i]  = '0;
                        end else if (frame_tick) begin
                            if (r_dist[i] <= w_speed[i]) begin
                                w_state_nx[i] = S_DONE;
                                w_dist_nx[i]  = '0;
                                w_reach[i]    = 1'b1;
                            end else begin
                                w_dist_nx[i] = r_dist[i] - w_speed[i];
                            end
                        end
                    end
                    default: ;
                endcase
            end
            w_alive_nx[i] = (w_state_nx[i] == S_ALIVE);
            w_enemies_nx  = w_enemies_nx
                          | (w_state_nx[i] == S_WAIT)
                          | (w_state_nx[i] == S_ALIVE);
        end
        w_dmg_nx = 2'(w_reach[0]) + 2'(w_reach[1])
                 + 2'(w_reach[2]);
    end

    always_ff @(posedge Clk) begin
        if (Reset_h) begin
            for (int i = 0; i < 3; i++) begin
                r_state[i] <= S_IDLE;
                r_cnt[i]   <= '0;
                r_dist[i]  <= '0;
            end
            r_alive   <= '0;
            r_enemies <= 1'b0;
            r_dmg     <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                r_state[i] <= w_state_nx[i];
                r_cnt[i]   <= w_cnt_nx[i];
                r_dist[i]  <= w_dist_nx[i];
            end
            r_alive   <= w_alive_nx;
            r_enemies <= w_enemies_nx;
            r_dmg     <= w_dmg_nx;
        end
    end

    assign zombie_alive = r_alive;
    assign z0_dist      = r_dist[0];
    assign z1_dist      = r_dist[1];
    assign z2_dist      = r_dist[2];
    assign enemies      = r_enemies;
    assign damage_cnt   = r_dmg;

endmodule

// File: tb/tb_zombie_spawner.sv
// Scoreboard bench for zombie_spawner: stimulus queues expectations,
// monitors pop and compare snapshots and damage pulses.
module tb_zombie_spawner;

    logic       Clk = 1'b0;
    logic       Reset_h = 1'b1;
    logic       frame_tick = 1'b0;
    logic       new_level = 1'b0;
    logic       play_active = 1'b0;
    logic [9:0] z0_speed = '0, z1_speed = '0, z2_speed = '0;
    logic [9:0] z0_delay = '0, z1_delay = '0, z2_delay = '0;
    logic [2:0] kill = '0;
    logic [2:0] zombie_alive;
    logic [9:0] z0_dist, z1_dist, z2_dist;
    logic       enemies;
    logic [1:0] damage_cnt;

    zombie_spawner dut (
        .Clk(Clk), .Reset_h(Reset_h), .frame_tick(frame_tick),
        .new_level(new_level), .play_active(play_active),
        .z0_speed(z0_speed), .z1_speed(z1_speed), .z2_speed(z2_speed),
        .z0_delay(z0_delay), .z1_delay(z1_delay), .z2_delay(z2_delay),
        .kill(kill), .zombie_alive(zombie_alive),
        .z0_dist(z0_dist), .z1_dist(z1_dist), .z2_dist(z2_dist),
        .enemies(enemies), .damage_cnt(damage_cnt)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int         cyc;
        string      name;
        logic [2:0] alive;
        logic [9:0] d0, d1, d2;
        logic       en;
        logic [1:0] dmg;
    } snap_t;

    typedef struct {
        int         cyc;
        logic [1:0] val;
    } dmg_t;

    snap_t exp_q[$];
    dmg_t  dmg_q[$];
    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    // snapshot monitor
    always @(negedge Clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            snap_t e;
            e = exp_q.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                failures++;
                $display("FAIL %s stale: queued cyc=%0d now=%0d",
                         e.name, e.cyc, cyc);
            end else if (zombie_alive !== e.alive || z0_dist !== e.d0 ||
                         z1_dist !== e.d1 || z2_dist !== e.d2 ||
                         enemies !== e.en || damage_cnt !== e.dmg) begin
                failures++;
                $display("FAIL %s cyc=%0d got alive=%b d=%0d/%0d/%0d en=%b dmg=%0d exp alive=%b d=%0d/%0d/%0d en=%b dmg=%0d",
                         e.name, cyc, zombie_alive, z0_dist, z1_dist,
                         z2_dist, enemies, damage_cnt, e.alive, e.d0,
                         e.d1, e.d2, e.en, e.dmg);
            end
        end
    end

    // damage pulse monitor
    always @(negedge Clk) begin
        if (!Reset_h && damage_cnt !== 2'd0) begin
            checks++;
            if (dmg_q.size() == 0) begin
                failures++;
                $display("FAIL dmg_unexpected cyc=%0d got=%0d exp=none",
                         cyc, damage_cnt);
            end else begin
                dmg_t d;
                d = dmg_q.pop_front();
                if (d.val !== damage_cnt || d.cyc != cyc) begin
                    failures++;
                    $display("FAIL dmg_pulse got=%0d@%0d exp=%0d@%0d",
                             damage_cnt, cyc, d.val, d.cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic chk(input string n, input logic [2:0] a,
                       input logic [9:0] d0, input logic [9:0] d1,
                       input logic [9:0] d2, input logic en,
                       input logic [1:0] dmg);
        snap_t e;
        e.cyc = cyc; e.name = n; e.alive = a;
        e.d0 = d0; e.d1 = d1; e.d2 = d2; e.en = en; e.dmg = dmg;
        exp_q.push_back(e);
    endtask

    task automatic exp_dmg(input logic [1:0] v);
        dmg_t d;
        d.cyc = cyc; d.val = v;
        dmg_q.push_back(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d exp=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // T1 reset dominates a concurrent new_level
        Reset_h = 1'b1; new_level = 1'b1; play_active = 1'b1;
        step();
        step();
        chk("reset", 3'b000, 0, 0, 0, 0, 0);
        new_level = 1'b0;
        Reset_h = 1'b0;
        step();
        chk("idle_after_reset", 3'b000, 0, 0, 0, 0, 0);

        // T2 spawn timing
        z0_speed = 10'd7; z0_delay = 10'd3;
        z1_speed = 10'd0; z1_delay = 10'd1000;
        z2_speed = 10'd0; z2_delay = 10'd1000;
        new_level = 1'b1;
        step();
        new_level = 1'b0;
        chk("armed", 3'b000, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("wait_delay", 3'b000, 0, 0, 0, 1, 0);
        end
        step();
        chk("idle_cycle_no_advance", 3'b000, 0, 0, 0, 1, 0);
        tick();
        chk("spawn", 3'b001, 10'd600, 0, 0, 1, 0);

        // T3 approach at speed 7
        for (int k = 1; k <= 85; k++) begin
            tick();
            chk("approach", 3'b001, 10'(600 - 7 * k), 0, 0, 1, 0);
        end
        tick();
        exp_dmg(2'd1);
        chk("reach", 3'b000, 0, 0, 0, 1, 1);
        step();
        chk("dmg_one_cycle", 3'b000, 0, 0, 0, 1, 0);
        tick();
        chk("done_holds", 3'b000, 0, 0, 0, 1, 0);

        // T4 kill beats reach, double reach
        z0_speed = 10'd600; z0_delay = 10'd0;
        z1_speed = 10'd300; z1_delay = 10'd0;
        z2_speed = 10'd300; z2_delay = 10'd0;
        new_level = 1'b1;
        step();
        new_level = 1'b0;
        chk("t4_armed", 3'b000, 0, 0, 0, 1, 0);
        tick();
        chk("t4_spawn", 3'b111, 600, 600, 600, 1, 0);
        kill = 3'b001;
        tick();
        kill = 3'b000;
        chk("kill_beats_reach", 3'b110, 0, 300, 300, 1, 0);
        tick();
        exp_dmg(2'd2);
        chk("double_reach", 3'b000, 0, 0, 0, 0, 2);
        step();
        chk("t4_after", 3'b000, 0, 0, 0, 0, 0);

        // T5 level clear by kills
        z0_speed = 10'd1; z0_delay = 10'd0;
        z1_speed = 10'd1; z1_delay = 10'd1;
        z2_speed = 10'd1; z2_delay = 10'd2;
        new_level = 1'b1;
        step();
        new_level = 1'b0;
        kill = 3'b111;
        step();
        kill = 3'b000;
        chk("kill_in_wait_ignored", 3'b000, 0, 0, 0, 1, 0);
        tick();
        chk("t5_tick1", 3'b001, 600, 0, 0, 1, 0);
        tick();
        chk("t5_tick2", 3'b011, 599, 600, 0, 1, 0);
        tick();
        chk("t5_tick3", 3'b111, 598, 599, 600, 1, 0);
        kill = 3'b111;
        step();
        kill = 3'b000;
        chk("level_clear", 3'b000, 0, 0, 0, 0, 0);
        step();
        chk("clear_holds", 3'b000, 0, 0, 0, 0, 0);
        z0_speed = 10'd0; z0_delay = 10'd0;
        z1_delay = 10'd5; z2_delay = 10'd5;
        new_level = 1'b1;
        step();
        new_level = 1'b0;
        chk("rearm", 3'b000, 0, 0, 0, 1, 0);
        tick();
        chk("speed0_spawn", 3'b001, 600, 0, 0, 1, 0);
        tick();
        chk("speed0_hold", 3'b001, 600, 0, 0, 1, 0);

        // T6 abort and reset mid-level
        play_active = 1'b0;
        step();
        chk("abort", 3'b000, 0, 0, 0, 0, 0);
        play_active = 1'b1;
        tick();
        chk("abort_stays_idle", 3'b000, 0, 0, 0, 0, 0);
        play_active = 1'b0;
        new_level = 1'b1;
        step();
        new_level = 1'b0;
        chk("nonplay_arm", 3'b000, 0, 0, 0, 1, 0);
        step();
        chk("nonplay_idle", 3'b000, 0, 0, 0, 0, 0);
        play_active = 1'b1;
        new_level = 1'b1;
        step();
        new_level = 1'b0;
        tick();
        chk("pre_reset_alive", 3'b001, 600, 0, 0, 1, 0);
        Reset_h = 1'b1;
        step();
        chk("reset_mid_alive", 3'b000, 0, 0, 0, 0, 0);
        Reset_h = 1'b0;
        tick();
        chk("post_reset_idle", 3'b000, 0, 0, 0, 0, 0);

        step();
        step();
        checks++;
        if (exp_q.size() != 0 || dmg_q.size() != 0) begin
            failures++;
            $display("FAIL queues_drained snap=%0d dmg=%0d exp=0/0",
                     exp_q.size(), dmg_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
